// File: rtl/cla_wide_add_sequencer.sv
// Wide add/sub sequencer: one 16-bit carry-lookahead adder reused across
// WORDS slices, LSB slice first, with the inter-slice carry held in a flop.

// 16-bit CLA built from four 4-bit lookahead groups.
module CLA_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        c_out,
  output logic        BP,
  output logic        BG
);
  logic [15:0] g, p;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;
  logic [15:0] c;

  // Bit and group generate/propagate, plus the carry into each group.
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) |
              (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = c_in;
    gc[1] = gg[0] | (gp[0] & c_in);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
            (gp[2] & gp[1] & gp[0] & c_in);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
            (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
    BP    = &gp;
    BG    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
            (gp[3] & gp[2] & gp[1] & gg[0]);
    c_out = gc[4];
  end

  // Per-bit carries inside each group, flattened lookahead from the group carry.
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        logic t, pp;
        t  = 1'b0;
        pp = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          t  = t | (pp & g[4*k+j]);
          pp = pp & p[4*k+j];
        end
        c[4*k+i] = t | (pp & gc[k]);
      end
    end
    s = p ^ c;
  end
endmodule

module cla_wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic              c_in,
  output logic              busy,
  output logic              done,
  output logic [16*WORDS-1:0] sum,
  output logic              c_out,
  output logic              ovf
);
  localparam int W     = 16 * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
  logic             cy_q, cy_d, c_out_q, c_out_d, ovf_q, ovf_d;

  logic [15:0] cla_a, cla_b, cla_s;
  logic        cla_co, cla_bp_unused, cla_bg_unused;

  assign cla_a = op_a_q[16*idx_q +: 16];
  assign cla_b = op_b_q[16*idx_q +: 16];

  CLA_16_bit u_cla (
    .a     (cla_a),
    .b     (cla_b),
    .c_in  (cy_q),
    .s     (cla_s),
    .c_out (cla_co),
    .BP    (cla_bp_unused),
    .BG    (cla_bg_unused)
  );

  // Sequencing: latch operands in IDLE, walk one slice per cycle in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        // Subtraction is a + ~b + 1; c_in only matters for add.
        op_a_d  = a;
        op_b_d  = sub ? ~b : b;
        cy_d    = sub ? 1'b1 : c_in;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[16*idx_q +: 16] = cla_s;
        cy_d  = cla_co;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          c_out_d = cla_co;
          ovf_d   = (op_a_q[W-1] == op_b_q[W-1]) & (cla_s[15] != op_a_q[W-1]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
endmodule
